// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package mem_resp_pkg;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned OFFS_BITS  = 3;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic                    write;
    logic [DATA_W-1:0]       addr;
    logic [DATA_W-1:0]       wdata;
    logic [WORD_BYTES-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word array with per-byte write enables and a registered read port.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic                  clr_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [WORD_BYTES-1:0] be_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < int'(WORD_BYTES); b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end else if (clr_i) begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: latches one request, waits LATENCY cycles, then holds
// the response until the core consumes it.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DATA_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [WORD_BYTES-1:0] req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  // Zero latency still spends one edge in WAIT so the RAM read is registered.
  localparam int unsigned START_CNT = (LATENCY == 0) ? 1 : LATENCY;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q, req_d;
  logic             err_q, err_d;
  logic             access;
  logic             resp_hs;
  logic             addr_err;

  assign addr_err = (|req_q.addr[OFFS_BITS-1:0]) ||
                    (|req_q.addr[DATA_W-1:ADDR_W+OFFS_BITS]);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    access  = 1'b0;
    resp_hs = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d.write = req_write;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          req_d.be    = req_be;
          cnt_d       = CNT_W'(START_CNT);
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          access  = 1'b1;
          err_d   = addr_err;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_hs = 1'b1;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stores, errors and the response handshake all leave read data at zero.
  mem_resp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (CLK),
    .rst_i   (reset),
    .en_i    (access && !addr_err),
    .we_i    (req_q.write),
    .clr_i   (resp_hs || (access && (req_q.write || addr_err))),
    .addr_i  (req_q.addr[ADDR_W+OFFS_BITS-1:OFFS_BITS]),
    .wdata_i (req_q.wdata),
    .be_i    (req_q.be),
    .rdata_o (resp_rdata)
  );

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives a LATENCY=2 and a LATENCY=0 responder in lockstep and checks both
// against a word-array model of the memory.
module tb_data_mem_responder;

  localparam int unsigned AW = 10;

  logic        clk;
  logic        reset;
  logic        req_valid, req_write, resp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_be;

  logic        req_ready, resp_valid, resp_err, busy;
  logic [63:0] resp_rdata;
  logic        z_req_ready, z_resp_valid, z_resp_err, z_busy;
  logic [63:0] z_resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem_m [int unsigned];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(AW), .LATENCY(2)) u_dut (
    .CLK(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  data_mem_responder #(.ADDR_W(AW), .LATENCY(0)) u_dut_l0 (
    .CLK(clk), .reset(reset), .req_valid(req_valid), .req_ready(z_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .resp_valid(z_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_err(input logic [63:0] a);
    return (a[2:0] != 3'd0) || ((a >> 3) >= (64'd1 << AW));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"},  64'(req_ready),    64'd1);
    check({tag, "_busy"},   64'(busy),         64'd0);
    check({tag, "_valid"},  64'(resp_valid),   64'd0);
    check({tag, "_rdata"},  resp_rdata,        64'd0);
    check({tag, "_err"},    64'(resp_err),     64'd0);
    check({tag, "_ready0"}, 64'(z_req_ready),  64'd1);
    check({tag, "_busy0"},  64'(z_busy),       64'd0);
    check({tag, "_valid0"}, 64'(z_resp_valid), 64'd0);
    check({tag, "_rdata0"}, z_resp_rdata,      64'd0);
  endtask

  // One full transaction on both DUTs; resp_ready is held low for `hold` extra cycles.
  task automatic txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] be, input int hold, output logic [63:0] rd);
    logic [63:0] exp_d;
    logic        exp_e, known;
    int unsigned w;
    int          k, k0, k2;
    exp_e = is_err(addr);
    w     = 32'(addr >> 3);
    exp_d = 64'd0;
    known = 1'b1;
    if (!exp_e && !wr) begin
      known = mem_m.exists(w);
      if (known) exp_d = mem_m[w];
    end

    @(negedge clk);
    check("pre_ready",  64'(req_ready),   64'd1);
    check("pre_ready0", 64'(z_req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Request lines are scrambled after the accept edge; the latch must ignore them.
    req_valid = 1'b0; req_write = ~wr;
    req_addr  = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    req_be    = 8'($urandom);
    check("acc_busy",  64'(busy),      64'd1);
    check("acc_ready", 64'(req_ready), 64'd0);

    k = 0; k0 = 0; k2 = 0;
    while ((k0 == 0 || k2 == 0) && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (z_resp_valid && k0 == 0) k0 = k;
      if (resp_valid && k2 == 0)   k2 = k;
    end
    check("latency2", 64'(k2), 64'd2);
    check("latency0", 64'(k0), 64'd1);
    rd = resp_rdata;
    check("resp_err",  64'(resp_err),   64'(exp_e));
    check("resp_err0", 64'(z_resp_err), 64'(exp_e));
    if (known) begin
      check("resp_rdata",  resp_rdata,   exp_d);
      check("resp_rdata0", z_resp_rdata, exp_d);
    end

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_rdata", resp_rdata,      rd);
      check("hold_err",   64'(resp_err),   64'(exp_e));
      check("hold_ready", 64'(req_ready),  64'd0);
      check("hold_busy",  64'(busy),       64'd1);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check_idle("post_hs");

    if (!exp_e && wr && (mem_m.exists(w) || be == 8'hFF)) begin
      logic [63:0] cur;
      cur = mem_m.exists(w) ? mem_m[w] : 64'd0;
      for (int b = 0; b < 8; b++) if (be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
      mem_m[w] = cur;
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] pre;
    int unsigned pool [16];

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;
    #1;
    check_idle("reset_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("after_reset");

    // Directed: full store, read back, partial store, merged read back.
    txn(1'b1, 64'h40, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, rd);
    check("dir_store_rdata", rd, 64'd0);
    txn(1'b0, 64'h40, 64'd0, 8'h00, 0, rd);
    check("dir_load", rd, 64'h1234_5678_9ABC_DEF0);
    txn(1'b1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, rd);
    txn(1'b0, 64'h40, 64'd0, 8'h00, 0, rd);
    check("dir_merge", rd, 64'h1234_5678_FFFF_FFFF);

    // Misaligned and out-of-range loads, then an unchanged read back.
    txn(1'b0, 64'h44, 64'd0, 8'h00, 0, rd);
    check("dir_misalign_rdata", rd, 64'd0);
    txn(1'b0, 64'd1 << (AW + 3), 64'd0, 8'h00, 0, rd);
    check("dir_oor_rdata", rd, 64'd0);
    txn(1'b1, (64'd1 << (AW + 3)) - 64'd8, 64'hA5A5_0000_1111_2222, 8'hFF, 0, rd);
    txn(1'b0, 64'h40, 64'd0, 8'h00, 0, rd);
    check("dir_after_err", rd, 64'h1234_5678_FFFF_FFFF);

    // Empty byte-enable store, then a load held for five cycles.
    txn(1'b1, 64'h40, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 0, rd);
    txn(1'b0, 64'h40, 64'd0, 8'h00, 5, rd);
    check("dir_be0", rd, 64'h1234_5678_FFFF_FFFF);

    // Reset during WAIT drops the pending store.
    pre = 64'h1234_5678_FFFF_FFFF;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40;
    req_wdata = 64'h0BAD_0BAD_0BAD_0BAD; req_be = 8'hFF;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_idle("reset_wait");
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    txn(1'b0, 64'h40, 64'd0, 8'h00, 0, rd);
    check("dir_reset_drop", rd, pre);

    // Random traffic over a small word pool that includes both ends of the array.
    pool[0] = 0;
    pool[1] = (1 << AW) - 1;
    for (int i = 2; i < 16; i++) pool[i] = $urandom_range((1 << AW) - 1, 0);
    for (int i = 0; i < 16; i++)
      txn(1'b1, 64'(pool[i]) << 3, {$urandom, $urandom}, 8'hFF, 0, rd);
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a;
      int unsigned r;
      a = 64'(pool[$urandom_range(15, 0)]) << 3;
      r = $urandom_range(19, 0);
      if (r == 0)      a = a | 64'($urandom_range(7, 1));
      else if (r == 1) a = a + (64'($urandom_range(8, 1)) << (AW + 3));
      else if (r == 2) a = a | (64'd1 << 63);
      txn(1'($urandom_range(1, 0)), a, {$urandom, $urandom}, 8'($urandom),
          int'($urandom_range(2, 0)), rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
